// File: rtl/rv32i_control_fsm.sv
// Multi-cycle F/D/E/M/WB sequencer for the RV32I ALU datapath; owns pc, ir and instret.
// Macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes set o_illegal and park in HALT; otherwise they retire as NOPs.
module rv32i_control_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_enable,
  input  logic [31:0] i_instr_in,
  input  logic        i_mem_ack,
  input  logic [31:0] i_imm,
  input  logic        i_branch,
  input  logic [31:0] i_alu_result,
  output logic [31:0] o_pc,
  output logic [31:0] o_ir,
  output logic        o_alu_source,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_addr_sel,
  output logic        o_reg_write,
  output logic [31:0] o_instret,
  output logic [2:0]  o_state,
  output logic        o_illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  typedef struct packed {
    logic alu_source;
    logic mem_read;
    logic mem_write;
    logic addr_sel;
    logic reg_write;
  } strobe_t;

  state_t      r_state;
  strobe_t     r_strobe;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_instret;
  logic        r_br_q;
  logic [6:0]  w_opcode;

  assign w_opcode = r_ir[6:0];

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI);
  endfunction

  // Strobe pattern for the state being entered; registered so outputs are glitch-free Moore.
  function automatic strobe_t strobes_for(input state_t s, input logic [6:0] op);
    strobe_t so;
    logic    imm_op;
    so     = '0;
    imm_op = (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
             (op == OP_JALR) || (op == OP_LUI);
    case (s)
      S_FETCH: so.mem_read = 1'b1;
      S_DECODE, S_EXECUTE: so.alu_source = imm_op;
      S_MEM: begin
        so.alu_source = imm_op;
        so.addr_sel   = 1'b1;
        so.mem_read   = (op == OP_LOAD);
        so.mem_write  = (op == OP_STORE);
      end
      S_WRITEBACK: begin
        so.alu_source = imm_op;
        so.reg_write  = (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
                        (op == OP_LUI) || (op == OP_JAL) || (op == OP_JALR);
      end
      default: so = '0;
    endcase
    return so;
  endfunction

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  assign o_illegal = r_illegal;
`else
  assign o_illegal = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state   <= S_IDLE;
      r_strobe  <= '0;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_instret <= '0;
      r_br_q    <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_state  <= S_FETCH;
            r_strobe <= strobes_for(S_FETCH, w_opcode);
          end
        end
        S_FETCH: begin
          if (i_mem_ack) begin
            r_ir     <= i_instr_in;
            r_state  <= S_DECODE;
            r_strobe <= strobes_for(S_DECODE, i_instr_in[6:0]);
          end
        end
        S_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          if (!is_legal(w_opcode)) begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
            r_strobe  <= '0;
          end else begin
            r_state  <= S_EXECUTE;
            r_strobe <= strobes_for(S_EXECUTE, w_opcode);
          end
`else
          r_state  <= S_EXECUTE;
          r_strobe <= strobes_for(S_EXECUTE, w_opcode);
`endif
        end
        S_EXECUTE: begin
          r_br_q <= i_branch;
          if (is_mem_op(w_opcode)) begin
            r_state  <= S_MEM;
            r_strobe <= strobes_for(S_MEM, w_opcode);
          end else begin
            r_state  <= S_WRITEBACK;
            r_strobe <= strobes_for(S_WRITEBACK, w_opcode);
          end
        end
        S_MEM: begin
          if (i_mem_ack) begin
            r_state  <= S_WRITEBACK;
            r_strobe <= strobes_for(S_WRITEBACK, w_opcode);
          end
        end
        S_WRITEBACK: begin
          case (w_opcode)
            OP_BR:   r_pc <= r_br_q ? (r_pc + i_imm) : (r_pc + 32'd4);
            OP_JAL:  r_pc <= r_pc + i_imm;
            OP_JALR: r_pc <= i_alu_result & 32'hFFFF_FFFE;
            default: r_pc <= r_pc + 32'd4;
          endcase
          r_instret <= r_instret + 32'd1;
          if (i_enable) begin
            r_state  <= S_FETCH;
            r_strobe <= strobes_for(S_FETCH, w_opcode);
          end else begin
            r_state  <= S_IDLE;
            r_strobe <= '0;
          end
        end
        S_HALT: r_strobe <= '0;
        default: begin
          r_state  <= S_IDLE;
          r_strobe <= '0;
        end
      endcase
    end
  end

  assign o_pc         = r_pc;
  assign o_ir         = r_ir;
  assign o_instret    = r_instret;
  assign o_state      = r_state;
  assign o_alu_source = r_strobe.alu_source;
  assign o_mem_read   = r_strobe.mem_read;
  assign o_mem_write  = r_strobe.mem_write;
  assign o_addr_sel   = r_strobe.addr_sel;
  assign o_reg_write  = r_strobe.reg_write;

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Randomized and directed bench for rv32i_control_fsm against an instruction-level reference model.
module tb_rv32i_control_fsm;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_LW   = 32'h0000_A083;
  localparam logic [31:0] I_SW   = 32'h0020_A023;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_8067;
  localparam logic [31:0] I_ILL  = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        nrst, enable, mem_ack, branch;
  logic [31:0] instr_in, imm, alu_result;
  logic [31:0] pc, ir, instret;
  logic        alu_source, mem_read, mem_write, addr_sel, reg_write, illegal;
  logic [2:0]  state;

  always #5 clk = ~clk;

  rv32i_control_fsm #(.RESET_PC(RESET_PC)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_enable(enable), .i_instr_in(instr_in),
    .i_mem_ack(mem_ack), .i_imm(imm), .i_branch(branch), .i_alu_result(alu_result),
    .o_pc(pc), .o_ir(ir), .o_alu_source(alu_source), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_addr_sel(addr_sel), .o_reg_write(reg_write),
    .o_instret(instret), .o_state(state), .o_illegal(illegal)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;

  typedef struct {
    int cycles, rd_f, rd_m, wr, rw, addr1, unstable, ir_bad, halted, timeout, nseq;
    logic [7:0][2:0] seq;
    logic        alusrc;
    logic [31:0] pc_after, instret_after;
    logic [2:0]  st_after;
  } meas_t;

  // ---------------- reference model (instruction level) ----------------
  function automatic logic legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI};
  endfunction
  function automatic logic [31:0] ref_pc(input logic [6:0] op, input logic [31:0] p, im, alu,
                                         input logic br);
    if (op == OP_JAL || (op == OP_BR && br)) return p + im;
    if (op == OP_JALR) return {alu[31:1], 1'b0};
    return p + 32'd4;
  endfunction
  function automatic int ref_cycles(input logic [6:0] op, input int fw, mw);
    return (op == OP_LOAD || op == OP_STORE) ? 5 + fw + mw : 4 + fw;
  endfunction
  function automatic int ref_rw(input logic [6:0] op);
    return (op inside {OP_R, OP_I, OP_LOAD, OP_LUI, OP_JAL, OP_JALR}) ? 1 : 0;
  endfunction
  function automatic logic ref_imm(input logic [6:0] op);
    return op inside {OP_I, OP_LOAD, OP_STORE, OP_JALR, OP_LUI};
  endfunction

  // Drives one instruction from IDLE/FETCH through writeback (or HALT) and records what it saw.
  task automatic run_instr(input logic [31:0] ins, im, alu, input logic br, input int fw, mw,
                           input logic en_mid, en_after, output meas_t m);
    int fc, mc;
    logic [2:0] st;
    logic [31:0] pc0, ic0, r;
    logic done;
    m = '{default: 0};
    fc = 0; mc = 0; done = 1'b0;
    pc0 = pc; ic0 = instret;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      st = state;
      if (st == ST_HALT) begin m.halted = 1; break; end
      if (st != ST_IDLE) begin
        m.cycles++;
        if (m.nseq < 8) begin m.seq[m.nseq] = st; m.nseq++; end
        if (mem_read && st == ST_FETCH) m.rd_f++;
        if (mem_read && st != ST_FETCH) m.rd_m++;
        if (mem_write) m.wr++;
        if (reg_write) m.rw++;
        if (addr_sel) m.addr1++;
        if (pc !== pc0 || instret !== ic0) m.unstable++;
      end
      if (st == ST_EXEC && ir !== ins) m.ir_bad++;
      if (st == ST_WB) m.alusrc = alu_source;
      r = $urandom;
      instr_in   = (st == ST_FETCH) ? ins : r;
      imm        = im;
      alu_result = alu;
      branch     = br;
      enable     = (st == ST_IDLE) ? 1'b1 : (st == ST_WB) ? en_after : en_mid;
      case (st)
        ST_FETCH: begin mem_ack = (fc == fw); fc++; end
        ST_MEM:   begin mem_ack = (mc == mw); mc++; end
        default:  mem_ack = 1'($urandom_range(0, 1));
      endcase
      if (st == ST_WB) begin
        @(posedge clk); #1;
        m.pc_after = pc; m.instret_after = instret; m.st_after = state;
        done = 1'b1;
        break;
      end
    end
    if (!done && m.halted == 0) m.timeout = 1;
    mem_ack = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    meas_t m;
    run_instr(I_JAL, target - exp_pc, 32'h0, 1'b0, 0, 0, 1'b1, 1'b1, m);
    exp_pc = target;
    exp_instret++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    nrst = 1'b0; enable = 1'b0; mem_ack = 1'b0; branch = 1'b0;
    instr_in = '0; imm = '0; alu_result = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== ST_IDLE || pc !== RESET_PC || ir !== 32'h0 || instret !== 32'h0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_regs: state=%0d pc=%h ir=%h instret=%0d illegal=%b want 0/%h/0/0/0",
                         state, pc, ir, instret, illegal, RESET_PC);
    end
    checks++;
    if ({alu_source, mem_read, mem_write, addr_sel, reg_write} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000",
                         {alu_source, mem_read, mem_write, addr_sel, reg_write});
    end
    nrst = 1'b1;
    exp_pc = RESET_PC; exp_instret = 0;
  endtask

  task automatic test_addi;
    meas_t m;
    run_instr(I_ADDI, 32'd5, 32'h0, 1'b0, 0, 0, 1'b1, 1'b1, m);
    exp_pc += 4; exp_instret++;
    checks++;
    if ({m.seq[0], m.seq[1], m.seq[2], m.seq[3]} !== {ST_FETCH, ST_DECODE, ST_EXEC, ST_WB} || m.cycles != 4) begin
      errors++; $display("FAIL addi_states: got %h cycles=%0d want 1,2,3,5 in 4",
                         {m.seq[0], m.seq[1], m.seq[2], m.seq[3]}, m.cycles);
    end
    checks++;
    if (m.rw != 1 || m.alusrc !== 1'b1) begin
      errors++; $display("FAIL addi_strobes: reg_write=%0d alu_source=%b want 1/1", m.rw, m.alusrc);
    end
    checks++;
    if (m.pc_after !== 32'h4 || m.instret_after !== 32'd1) begin
      errors++; $display("FAIL addi_retire: pc=%h instret=%0d want 4/1", m.pc_after, m.instret_after);
    end
  endtask

  task automatic test_load;
    meas_t m;
    run_instr(I_LW, 32'h0, 32'h40, 1'b0, 3, 3, 1'b1, 1'b1, m);
    exp_pc += 4; exp_instret++;
    checks++;
    if (m.cycles != 11 || m.rd_f != 4 || m.rd_m != 4) begin
      errors++; $display("FAIL load_timing: cycles=%0d rd_f=%0d rd_m=%0d want 11/4/4", m.cycles, m.rd_f, m.rd_m);
    end
    checks++;
    if (m.addr1 != 4 || m.rw != 1 || m.wr != 0) begin
      errors++; $display("FAIL load_strobes: addr_sel=%0d reg_write=%0d mem_write=%0d want 4/1/0", m.addr1, m.rw, m.wr);
    end
    checks++;
    if (m.pc_after !== exp_pc || m.unstable != 0) begin
      errors++; $display("FAIL load_pc: pc=%h unstable=%0d want %h/0", m.pc_after, m.unstable, exp_pc);
    end
  endtask

  task automatic test_branch;
    meas_t m;
    goto_pc(32'h10);
    run_instr(I_BEQ, 32'hFFFF_FFF8, 32'h0, 1'b1, 0, 0, 1'b1, 1'b1, m);
    exp_instret++;
    checks++;
    if (m.pc_after !== 32'h08 || m.rw != 0) begin
      errors++; $display("FAIL beq_taken: pc=%h reg_write=%0d want 00000008/0", m.pc_after, m.rw);
    end
    exp_pc = 32'h08;
    goto_pc(32'h10);
    run_instr(I_BEQ, 32'hFFFF_FFF8, 32'h0, 1'b0, 0, 0, 1'b1, 1'b1, m);
    exp_instret++;
    checks++;
    if (m.pc_after !== 32'h14 || m.rw != 0) begin
      errors++; $display("FAIL beq_not_taken: pc=%h reg_write=%0d want 00000014/0", m.pc_after, m.rw);
    end
    exp_pc = 32'h14;
  endtask

  task automatic test_jalr_store_wrap;
    meas_t m;
    run_instr(I_JALR, 32'h0, 32'h0000_0123, 1'b0, 1, 0, 1'b1, 1'b1, m);
    exp_pc = 32'h122; exp_instret++;
    checks++;
    if (m.pc_after !== 32'h0000_0122 || m.rw != 1) begin
      errors++; $display("FAIL jalr: pc=%h reg_write=%0d want 00000122/1", m.pc_after, m.rw);
    end
    run_instr(I_SW, 32'h0, 32'h80, 1'b0, 0, 2, 1'b1, 1'b1, m);
    exp_pc += 4; exp_instret++;
    checks++;
    if (m.wr != 3 || m.rw != 0 || m.rd_m != 0 || m.cycles != 7) begin
      errors++; $display("FAIL store: mem_write=%0d reg_write=%0d rd_m=%0d cycles=%0d want 3/0/0/7",
                         m.wr, m.rw, m.rd_m, m.cycles);
    end
    goto_pc(32'hFFFF_FFFC);
    run_instr(I_ADDI, 32'd5, 32'h0, 1'b0, 0, 0, 1'b1, 1'b1, m);
    exp_pc = 32'h0; exp_instret++;
    checks++;
    if (m.pc_after !== 32'h0 || m.instret_after !== exp_instret) begin
      errors++; $display("FAIL pc_wrap: pc=%h instret=%0d want 00000000/%0d", m.pc_after, m.instret_after, exp_instret);
    end
  endtask

  task automatic test_random;
    meas_t m;
    logic [6:0] op;
    logic [6:0] ops [8] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    logic [31:0] r, ins, im, alu, npc;
    logic br, en_after;
    int fw, mw;
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 7)];
`ifndef CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) begin
        do begin r = $urandom; op = r[6:0]; end while (legal(op));
      end
`endif
      r = $urandom; ins = {r[31:7], op};
      im = $urandom; alu = $urandom; br = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3); mw = $urandom_range(0, 3);
      en_after = ($urandom_range(0, 3) != 0);
      run_instr(ins, im, alu, br, fw, mw, 1'b1, en_after, m);
      npc = ref_pc(op, exp_pc, im, alu, br);
      exp_instret++;
      checks++;
      if (m.pc_after !== npc || m.instret_after !== exp_instret) begin
        errors++; $display("FAIL rnd_pc[%0d]: ins=%h pc=%h instret=%0d want %h/%0d",
                           n, ins, m.pc_after, m.instret_after, npc, exp_instret);
      end
      checks++;
      if (m.cycles != ref_cycles(op, fw, mw) || m.rw != ref_rw(op) || m.alusrc !== ref_imm(op)) begin
        errors++; $display("FAIL rnd_timing[%0d]: ins=%h cycles=%0d rw=%0d alusrc=%b want %0d/%0d/%b",
                           n, ins, m.cycles, m.rw, m.alusrc, ref_cycles(op, fw, mw), ref_rw(op), ref_imm(op));
      end
      checks++;
      if (m.st_after !== (en_after ? ST_FETCH : ST_IDLE) || m.unstable != 0 || m.ir_bad != 0 || m.timeout != 0) begin
        errors++; $display("FAIL rnd_flow[%0d]: next=%0d unstable=%0d ir_bad=%0d timeout=%0d want %0d/0/0/0",
                           n, m.st_after, m.unstable, m.ir_bad, m.timeout, en_after ? ST_FETCH : ST_IDLE);
      end
      exp_pc = npc;
    end
  endtask

  task automatic test_enable_drop;
    meas_t m;
    run_instr(I_ADDI, 32'd5, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0, m);
    exp_pc += 4; exp_instret++;
    checks++;
    if (m.st_after !== ST_IDLE || m.instret_after !== exp_instret || m.cycles != 4) begin
      errors++; $display("FAIL enable_drop: next=%0d instret=%0d cycles=%0d want 0/%0d/4",
                         m.st_after, m.instret_after, m.cycles, exp_instret);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (state !== ST_IDLE || mem_read !== 1'b0) begin
      errors++; $display("FAIL idle_hold: state=%0d mem_read=%b want 0/0", state, mem_read);
    end
  endtask

  task automatic test_illegal;
    meas_t m;
    run_instr(I_ILL, 32'h0, 32'h0, 1'b0, 1, 0, 1'b1, 1'b1, m);
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++;
    if (m.halted != 1 || illegal !== 1'b1 || m.cycles != 3) begin
      errors++; $display("FAIL illegal_halt: halted=%0d illegal=%b cycles=%0d want 1/1/3", m.halted, illegal, m.cycles);
    end
    repeat (3) begin @(negedge clk); mem_ack = ~mem_ack; end
    checks++;
    if (state !== ST_HALT || pc !== exp_pc || instret !== exp_instret ||
        {mem_read, mem_write, reg_write, addr_sel} !== 4'b0) begin
      errors++; $display("FAIL illegal_hold: state=%0d pc=%h instret=%0d want 6/%h/%0d, strobes 0",
                         state, pc, instret, exp_pc, exp_instret);
    end
    mem_ack = 1'b0;
`else
    exp_pc += 4; exp_instret++;
    checks++;
    if (m.pc_after !== exp_pc || m.instret_after !== exp_instret || m.rw != 0 || illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_nop: pc=%h instret=%0d rw=%0d illegal=%b want %h/%0d/0/0",
                         m.pc_after, m.instret_after, m.rw, illegal, exp_pc, exp_instret);
    end
`endif
  endtask

  task automatic test_reset_mid_mem;
    logic found;
    nrst = 1'b0; enable = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1; instr_in = I_LW; enable = 1'b1; found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (state == ST_MEM) begin found = 1'b1; break; end
      mem_ack = (state == ST_FETCH);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reach_mem: state=%0d want 4", state);
    end
    nrst = 1'b0; mem_ack = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== ST_IDLE || pc !== RESET_PC || instret !== 32'h0 || ir !== 32'h0 || illegal !== 1'b0 ||
        {alu_source, mem_read, mem_write, addr_sel, reg_write} !== 5'b0) begin
      errors++; $display("FAIL reset_in_mem: state=%0d pc=%h instret=%0d ir=%h strobes=%b want 0/%h/0/0/00000",
                         state, pc, instret, ir, {alu_source, mem_read, mem_write, addr_sel, reg_write}, RESET_PC);
    end
    nrst = 1'b1; mem_ack = 1'b0; enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_jalr_store_wrap();
    test_random();
    test_enable_drop();
    test_illegal();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_control_fsm.md
# rv32i_control_fsm

Multi-cycle sequencer for the RV32I core's ALU datapath. Owns the PC, instruction register and retired-instruction counter, and steps each instruction through fetch, decode, execute, memory and writeback. Drives the ALU operand select, memory request strobes and register-file write enable, and consumes the ALU's `branch` and `result` outputs. Sits between the memory interface, the instruction decoder/immediate generator and the ALU.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `nrst`  in  1  reset, synchronous, active-low.
- `enable`  in  1  run request; sampled in IDLE and WRITEBACK.
- `instr_in`  in  32  instruction word from memory; valid when `mem_ack`=1 in FETCH.
- `mem_ack`  in  1  memory completion pulse; ignored outside FETCH/MEM.
- `imm`  in  32  sign-extended immediate for current `ir`, from the decoder.
- `branch`  in  1  ALU branch/jump flag.
- `alu_result`  in  32  ALU result; used for the JALR target.
- `pc`  out  32  current instruction address.
- `ir`  out  32  latched instruction.
- `alu_source`  out  1  1 = immediate operand, 0 = reg2.
- `mem_read`  out  1  read request (fetch or load).
- `mem_write`  out  1  store request.
- `addr_sel`  out  1  0 = memory address from `pc`, 1 = from ALU.
- `reg_write`  out  1  register-file write strobe.
- `instret`  out  32  retired-instruction count.
- `state`  out  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6.
- `illegal`  out  1  sticky illegal-opcode flag (macro only; otherwise tied 0).

## Operation
- `opcode` = `ir[6:0]`. Legal values: 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch), 1101111 (JAL), 1100111 (JALR), 0110111 (LUI).
- IDLE: if `enable`=1, go to FETCH.
- FETCH: `mem_read`=1, `addr_sel`=0. Hold until `mem_ack`=1. On that edge, latch `ir`<=`instr_in` and go to DECODE.
- DECODE: one cycle. Go to EXECUTE, or to HALT when the opcode is illegal and the macro is set.
- EXECUTE: one cycle. Register `branch` as `br_q`. Load/store go to MEM; all other opcodes go to WRITEBACK.
- MEM: `addr_sel`=1. Load drives `mem_read`=1; store drives `mem_write`=1. Hold until `mem_ack`, then go to WRITEBACK.
- WRITEBACK: one cycle. `reg_write`=1 for R, I-ALU, load, LUI, JAL and JALR.
  - PC update on exit:
    - branch opcode with `br_q`=1: `pc+imm`
    - JAL: `pc+imm`
    - JALR: `{alu_result[31:1],1'b0}`
    - otherwise: `pc+4`
  - All PC arithmetic is modulo 2^32 (wraps at 32'hFFFF_FFFC+4 = 0).
  - `instret` increments (wraps). Next state is FETCH if `enable`=1, else IDLE.
- `alu_source`=1 for I-ALU, load, store, JALR and LUI; 0 otherwise. Valid in DECODE, EXECUTE, MEM and WRITEBACK.
- `enable` deasserted mid-instruction does not abort: the instruction completes, then the FSM enters IDLE.
- HALT: absorbing; only reset leaves it. All strobes are 0.

## Timing
- Outputs are Moore-decoded from `state`. Strobes are high every cycle the state is held, including the `mem_ack` cycle, and drop the cycle after.
- Reset (`nrst`=0 at an edge, any state): next cycle `state`=IDLE, `pc`=`RESET_PC`, `ir`=0, `instret`=0, `illegal`=0, and all strobes 0. Reset overrides a simultaneous `mem_ack`.
- With `mem_ack` in the first cycle of each wait:
  - non-memory instruction: 4 cycles (F, D, E, WB)
  - load/store: 5 cycles
  - each extra wait cycle adds 1
- `pc`, `ir` and `instret` change only on the edges stated above; they are stable throughout an instruction.
- A `mem_ack` in any state other than FETCH/MEM has no effect.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - an illegal opcode in DECODE sets `illegal`=1 and enters HALT
  - `pc` is left at the faulting address; `instret` is not incremented
- Not defined:
  - an illegal opcode is a NOP: passes E and WB with `reg_write`=0, `pc+4`, `instret`+1
  - `illegal` is tied 0 and HALT is unreachable

## Test plan
- Reset, `enable`=1, ack immediately, `instr_in`=ADDI (0x00500093) -> states 1,2,3,5. `reg_write`=1 in WB; `alu_source`=1. `pc` 0→4, `instret`=1.
- LW with `mem_ack` delayed 3 cycles in both FETCH and MEM -> `mem_read` high 4 cycles in each, `addr_sel` 0 then 1. Total 11 cycles; `reg_write`=1 once.
- BEQ with `imm`=-8 at `pc`=0x10: `branch`=1 -> `pc`=0x08. `branch`=0 -> `pc`=0x14. `reg_write`=0 in both cases.
- JALR with `alu_result`=0x0000_0123 -> `pc`=0x0000_0122. SW -> `mem_write`=1 in MEM, `reg_write`=0. `pc` at 0xFFFF_FFFC with a non-jump -> wraps to 0.
- `instr_in`=0x0000_007F (illegal):
  - with the macro: HALT, `illegal`=1, `pc` unchanged
  - without the macro: `pc`+4, `instret`+1
- `nrst`=0 during MEM with `mem_ack`=1 the same cycle -> IDLE, `pc`=`RESET_PC`, no strobes. `enable`=0 during EXECUTE -> instruction retires, then IDLE.
